// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared op/state encodings and default width for the iterative mult/div unit
package multdiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
endpackage

// File: rtl/multdiv_iter.sv
// multdiv_iter: one-bit-per-cycle shift-add multiply / restoring divide datapath with sign fix-up
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             sgn,
  input  logic             fix_en,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  logic [WIDTH-1:0] a, q, b;
  logic ns, ds, div_r;
  logic rs_neg, rt_neg, ok;
  logic [WIDTH-1:0] rs_abs, rt_abs, quot_c, rem_c;
  logic [WIDTH:0] mul_sum, shr, diff;
  logic [2*WIDTH-1:0] prod_c;
  assign rs_neg  = sgn & rs_data[WIDTH-1];
  assign rt_neg  = sgn & rt_data[WIDTH-1];
  assign rs_abs  = rs_neg ? -rs_data : rs_data;
  assign rt_abs  = rt_neg ? -rt_data : rt_data;
  assign mul_sum = {1'b0, a} + (q[0] ? {1'b0, b} : '0);
  assign shr     = {a, q[WIDTH-1]};
  assign diff    = shr - {1'b0, b};
  assign ok      = ~diff[WIDTH];
  assign prod_c  = (ns ^ ds) ? -{a, q} : {a, q};
  assign quot_c  = (ns ^ ds) ? -q : q;
  assign rem_c   = ns ? -a : a;
  // fix_en low means the registers already hold the divide-by-zero result verbatim
  assign res_hi  = !fix_en ? a : div_r ? rem_c : prod_c[2*WIDTH-1:WIDTH];
  assign res_lo  = !fix_en ? q : div_r ? quot_c : prod_c[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a     <= '0;
      q     <= '0;
      b     <= '0;
      ns    <= 1'b0;
      ds    <= 1'b0;
      div_r <= 1'b0;
    end else if (load) begin
      div_r <= is_div;
      ns    <= rs_neg;
      ds    <= rt_neg;
      b     <= is_div ? rt_abs : rs_abs;
      a     <= (is_div && rt_data == '0) ? rs_data : '0;
      q     <= (is_div && rt_data == '0) ? '1 : is_div ? rs_abs : rt_abs;
    end else if (step) begin
      if (div_r) begin
        a <= ok ? diff[WIDTH-1:0] : shr[WIDTH-1:0];
        q <= {q[WIDTH-2:0], ok};
      end else begin
        {a, q} <= {mul_sum, q[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences the iterative mult/div unit, owns HI/LO and the EX-stage stall
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [1:0]       mt_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic dz, load, div0;
  logic [WIDTH-1:0] res_hi, res_lo;
  assign busy  = state != S_IDLE;
  assign done  = state == S_FIX;
  assign stall = busy & (mf_req | start | (|mt_we));
  assign load  = state == S_IDLE && start;
  assign div0  = op[1] && rt_data == '0;
  multdiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .rst(rst), .load(load), .step(state == S_CALC), .is_div(op[1]),
    .sgn(~op[0]), .fix_en(~dz), .rs_data(rs_data), .rt_data(rt_data),
    .res_hi(res_hi), .res_lo(res_lo)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      dz    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (load) begin
      cnt   <= '0;
      dz    <= div0;
      state <= div0 ? S_FIX : S_CALC;
    end else if (state == S_IDLE) begin
      if (mt_we[1]) hi <= mt_data;
      if (mt_we[0]) lo <= mt_data;
    end else if (state == S_CALC) begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
    end else begin
      hi    <= res_hi;
      lo    <= res_lo;
      state <= S_IDLE;
    end
  end
endmodule
